uart_transmitter: RTL and testbench
===================================

Name: uart_transmitter

Overview:
- Serial transmit half of the UART link; the counterpart of the uart_receiver.
- Accepts a parallel byte on a single-cycle write strobe and serialises it on TxD as start, 8 data bits LSB-first, even parity, stop.
- Contains its own baud controller that generates the 16x oversample tick from the 50 MHz system clock and the baud_select code shared with the receiver.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz, used to derive the divisor table.
OVERSAMPLE, 16, baud ticks per transmitted bit; fixed to match the receiver.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset (0 = reset asserted).
Tx_DATA  input  8  byte to transmit; sampled only on an accepted write.
baud_select  input  3  baud code; sampled only on an accepted write.
Tx_EN  input  1  transmitter enable; writes are ignored while 0.
Tx_WR  input  1  one-cycle write strobe.
TxD  output  1  serial line, idle high.
Tx_BUSY  output  1  high while a frame is in flight.

Behaviour:
- Reset (reset=0, asynchronous):
  - TxD=1, Tx_BUSY=0, FSM=IDLE.
  - Baud counter, tick counter, bit index and shift register all cleared.
  - Reset asserted mid-frame aborts the frame immediately; TxD returns high in the same event.
- Baud divisor D (cycles per tick), as round(CLK_FREQ/(16*baud)):
  - 000=300 -> 10417
  - 001=1200 -> 2604
  - 010=4800 -> 651
  - 011=9600 -> 326
  - 100=19200 -> 163
  - 101=38400 -> 81
  - 110=57600 -> 54
  - 111=115200 -> 27
- Tick generation: a tick fires when the baud counter reaches D-1; the counter then wraps to 0. Every bit therefore lasts exactly 16*D clk cycles.
- Accept condition: Tx_WR=1 and Tx_EN=1 and Tx_BUSY=0, sampled at rising edge N. On accept:
  - Tx_DATA and baud_select are latched.
  - Parity bit = XOR of Tx_DATA (even parity).
  - Baud counter and tick counter are cleared.
- Ignored writes: Tx_WR while busy, or while Tx_EN=0, has no effect. Later changes to Tx_DATA or baud_select do not affect a frame in progress.
- FSM states and transitions: IDLE -> START -> DATA(x8) -> PARITY -> STOP -> IDLE.
  - IDLE: TxD=1, Tx_BUSY=0. Moves to START on accept.
  - START: from edge N+1, TxD=0 and Tx_BUSY=1. Held for 16 ticks.
  - DATA: TxD=latched bit[i], i=0..7, LSB first. Each bit held 16 ticks.
  - PARITY: TxD=parity bit, held 16 ticks.
  - STOP: TxD=1, held 16 ticks.
  - Leaving STOP: at edge N+1+11*16*D, FSM returns to IDLE and Tx_BUSY=0.
- Back-to-back frames: a write presented in the first cycle Tx_BUSY=0 is accepted. The next start bit begins on the following edge, with no extra idle gap.
- Tx_EN deasserted mid-frame: the current frame completes normally; only new writes are blocked.
- TxD is a registered output, glitch-free, and changes only on tick boundaries or on accept/reset.
- Bit index wraps 7 -> PARITY; it is never out of range.

Test Plan:
- Reset/idle: hold reset=0 for 400 ns, then release with no writes for 10000 ns -> TxD=1 and Tx_BUSY=0 throughout.
- Basic frame: baud_select=111, Tx_EN=1, Tx_DATA=8'b10011010, one-cycle Tx_WR.
  - TxD sequence 0,0,1,0,1,1,0,0,1,0,1, each level held exactly 432 cycles (8640 ns).
  - Tx_BUSY high for 4752 cycles.
- Odd parity byte: Tx_DATA=8'h07 at baud_select=111 -> parity bit=1; frame otherwise correct.
- Write blocking:
  - Tx_WR with Tx_EN=0 -> no frame.
  - Tx_WR mid-frame with 8'hFF -> ignored; the original byte completes intact.
- Back-to-back and baud latching:
  - 8'h55 then 8'hAA written in the first non-busy cycle -> second start bit begins on the next edge.
  - Changing baud_select to 000 mid-frame does not alter the current bit periods.
- Reset mid-frame: assert reset during DATA bit 3 -> TxD=1 and Tx_BUSY=0 immediately. After release, a fresh write to 8'hC3 produces a correct frame.

Source files
------------

// File: rtl/uart_transmitter.sv
// rtl/uart_transmitter.sv - UART transmitter: start, 8 data bits LSB-first, even parity, stop
// Built-in baud controller derives the 16x oversample tick from CLK_FREQ and baud_select.
module uart_transmitter #(
  parameter int CLK_FREQ   = 50000000,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] Tx_DATA,
  input  logic [2:0] baud_select,
  input  logic       Tx_EN,
  input  logic       Tx_WR,
  output logic       TxD,
  output logic       Tx_BUSY
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  // Divisor = round(CLK_FREQ / (OVERSAMPLE * baud))
  localparam int DIV_300    = (CLK_FREQ + (OVERSAMPLE * 300) / 2) / (OVERSAMPLE * 300);
  localparam int DIV_1200   = (CLK_FREQ + (OVERSAMPLE * 1200) / 2) / (OVERSAMPLE * 1200);
  localparam int DIV_4800   = (CLK_FREQ + (OVERSAMPLE * 4800) / 2) / (OVERSAMPLE * 4800);
  localparam int DIV_9600   = (CLK_FREQ + (OVERSAMPLE * 9600) / 2) / (OVERSAMPLE * 9600);
  localparam int DIV_19200  = (CLK_FREQ + (OVERSAMPLE * 19200) / 2) / (OVERSAMPLE * 19200);
  localparam int DIV_38400  = (CLK_FREQ + (OVERSAMPLE * 38400) / 2) / (OVERSAMPLE * 38400);
  localparam int DIV_57600  = (CLK_FREQ + (OVERSAMPLE * 57600) / 2) / (OVERSAMPLE * 57600);
  localparam int DIV_115200 = (CLK_FREQ + (OVERSAMPLE * 115200) / 2) / (OVERSAMPLE * 115200);

  state_t      state_q, state_d;
  logic [13:0] baud_cnt_q, baud_cnt_d;
  logic [3:0]  tick_cnt_q, tick_cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        parity_q, parity_d;
  logic [2:0]  sel_q, sel_d;
  logic        txd_q, txd_d;

  logic [13:0] div;
  logic        accept;
  logic        tick;
  logic        bit_end;

  // Divisor is decoded from the latched code so mid-frame baud_select changes have no effect.
  always_comb begin
    div = 14'(DIV_115200);
    case (sel_q)
      3'b000:  div = 14'(DIV_300);
      3'b001:  div = 14'(DIV_1200);
      3'b010:  div = 14'(DIV_4800);
      3'b011:  div = 14'(DIV_9600);
      3'b100:  div = 14'(DIV_19200);
      3'b101:  div = 14'(DIV_38400);
      3'b110:  div = 14'(DIV_57600);
      default: div = 14'(DIV_115200);
    endcase
  end

  assign accept  = Tx_WR && Tx_EN && (state_q == IDLE);
  assign tick    = (state_q != IDLE) && (baud_cnt_q == div - 14'd1);
  assign bit_end = tick && (tick_cnt_q == 4'(OVERSAMPLE - 1));

  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    tick_cnt_d = tick_cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    sel_d      = sel_q;
    txd_d      = txd_q;

    if (state_q != IDLE) begin
      baud_cnt_d = tick ? 14'd0 : baud_cnt_q + 14'd1;
      if (tick) begin
        tick_cnt_d = tick_cnt_q + 4'd1;
      end
    end

    case (state_q)
      IDLE: begin
        txd_d = 1'b1;
        if (accept) begin
          shift_d    = Tx_DATA;
          parity_d   = ^Tx_DATA;
          sel_d      = baud_select;
          baud_cnt_d = 14'd0;
          tick_cnt_d = 4'd0;
          bit_idx_d  = 3'd0;
          txd_d      = 1'b0;
          state_d    = START;
        end
      end
      START: begin
        if (bit_end) begin
          txd_d     = shift_q[0];
          bit_idx_d = 3'd0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_idx_q == 3'd7) begin
            txd_d   = parity_q;
            state_d = PARITY;
          end else begin
            txd_d     = shift_q[1];
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          txd_d   = 1'b1;
          state_d = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          txd_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        txd_d   = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      baud_cnt_q <= 14'd0;
      tick_cnt_q <= 4'd0;
      bit_idx_q  <= 3'd0;
      shift_q    <= 8'd0;
      parity_q   <= 1'b0;
      sel_q      <= 3'd0;
      txd_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      tick_cnt_q <= tick_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      sel_q      <= sel_d;
      txd_q      <= txd_d;
    end
  end

  assign TxD     = txd_q;
  assign Tx_BUSY = (state_q != IDLE);

endmodule

// File: tb/tb_uart_transmitter.sv
// tb/tb_uart_transmitter.sv - scoreboard bench for uart_transmitter
// Stimulus queues expected frames; a line monitor rebuilds each frame level by level.
module tb_uart_transmitter;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] Tx_DATA = 8'd0;
  logic [2:0] baud_select = 3'd0;
  logic       Tx_EN = 1'b0;
  logic       Tx_WR = 1'b0;
  logic       TxD;
  logic       Tx_BUSY;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [7:0] data;
    int         div;
    bit         abort;
  } exp_t;

  exp_t exp_q[$];
  int   div_tbl[8] = '{10417, 2604, 651, 326, 163, 81, 54, 27};

  uart_transmitter dut (
    .clk        (clk),
    .reset      (reset),
    .Tx_DATA    (Tx_DATA),
    .baud_select(baud_select),
    .Tx_EN      (Tx_EN),
    .Tx_WR      (Tx_WR),
    .TxD        (TxD),
    .Tx_BUSY    (Tx_BUSY)
  );

  always #10 clk = ~clk;

  task automatic check(input bit ok, input string name, input int got, input int want);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  // Called just after a negedge; holds Tx_WR across exactly one rising edge.
  task automatic write(input logic [7:0] d, input logic [2:0] s, input bit expect_acc,
                       input bit abort);
    exp_t e;
    if (expect_acc) begin
      e.data  = d;
      e.div   = div_tbl[s];
      e.abort = abort;
      exp_q.push_back(e);
    end
    Tx_DATA     = d;
    baud_select = s;
    Tx_WR       = 1'b1;
    @(negedge clk);
    Tx_WR = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while (Tx_BUSY !== 1'b0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (n >= limit) check(1'b0, "idle_timeout", n, limit);
  endtask

  // Reference frame: start 0, data LSB first, even parity, stop 1; each level 16*D cycles.
  task automatic check_frame();
    exp_t        e;
    logic [10:0] lv;
    int          errs;
    bit          aborted = 1'b0;
    if (exp_q.size() == 0) begin
      check(1'b0, "unexpected_frame", 1, 0);
      return;
    end
    e  = exp_q.pop_front();
    lv = {1'b1, ^e.data, e.data, 1'b0};
    for (int b = 0; b < 11 && !aborted; b++) begin
      errs = 0;
      for (int c = 0; c < 16 * e.div; c++) begin
        if (b != 0 || c != 0) @(negedge clk);
        if (!reset) begin
          aborted = 1'b1;
          break;
        end
        if (TxD !== lv[b] || Tx_BUSY !== 1'b1) errs++;
      end
      if (!aborted) check(errs == 0, $sformatf("level%0d_data%02h", b, e.data), errs, 0);
    end
    if (aborted) begin
      check(e.abort, "unexpected_abort", 1, int'(e.abort));
      return;
    end
    check(!e.abort, "abort_missing", 0, 1);
    @(negedge clk);
    check(Tx_BUSY === 1'b0 && TxD === 1'b1, "frame_end", int'(Tx_BUSY), 0);
  endtask

  initial begin : monitor
    logic prev_busy;
    prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        prev_busy = 1'b0;
      end else if (Tx_BUSY === 1'b1 && !prev_busy) begin
        check_frame();
        prev_busy = (reset === 1'b1) ? Tx_BUSY : 1'b0;
      end else begin
        prev_busy = Tx_BUSY;
      end
    end
  end

  initial begin : watchdog
    #4000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int errs;
    logic [7:0] d;
    logic [2:0] s;

    #200;
    check(TxD === 1'b1 && Tx_BUSY === 1'b0, "reset_state", int'(TxD), 1);
    #200;
    reset = 1'b1;
    errs  = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (TxD !== 1'b1 || Tx_BUSY !== 1'b0) errs++;
    end
    check(errs == 0, "idle_after_reset", errs, 0);

    Tx_EN = 1'b1;
    write(8'b10011010, 3'b111, 1'b1, 1'b0);
    wait_idle(20000);
    @(negedge clk);
    write(8'h07, 3'b111, 1'b1, 1'b0);
    wait_idle(20000);
    @(negedge clk);

    Tx_EN = 1'b0;
    write(8'h3C, 3'b111, 1'b0, 1'b0);
    errs = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (Tx_BUSY !== 1'b0 || TxD !== 1'b1) errs++;
    end
    check(errs == 0, "write_while_disabled", errs, 0);
    Tx_EN = 1'b1;

    // Mid-frame: ignored write, baud and data changes, enable dropped; frame must finish intact.
    write(8'h96, 3'b111, 1'b1, 1'b0);
    repeat (1000) @(negedge clk);
    write(8'hFF, 3'b000, 1'b0, 1'b0);
    Tx_DATA     = 8'h00;
    baud_select = 3'b000;
    repeat (500) @(negedge clk);
    Tx_EN = 1'b0;
    wait_idle(20000);
    Tx_EN = 1'b1;
    @(negedge clk);

    write(8'h55, 3'b111, 1'b1, 1'b0);
    wait_idle(20000);
    write(8'hAA, 3'b111, 1'b1, 1'b0);
    check(Tx_BUSY === 1'b1 && TxD === 1'b0, "back_to_back_start", int'(TxD), 0);
    wait_idle(20000);
    @(negedge clk);

    // Abort during data bit 3 (line level 4 spans cycles 1728..2159 at D=27).
    write(8'h5A, 3'b111, 1'b1, 1'b1);
    repeat (1900) @(negedge clk);
    #3;
    reset = 1'b0;
    #1;
    check(TxD === 1'b1 && Tx_BUSY === 1'b0, "reset_mid_frame", int'(Tx_BUSY), 0);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    write(8'hC3, 3'b111, 1'b1, 1'b0);
    wait_idle(20000);
    @(negedge clk);

    for (int k = 0; k < 3; k++) begin
      d = 8'($urandom);
      s = 3'($urandom_range(6, 7));
      write(d, s, 1'b1, 1'b0);
      wait_idle(20000);
      @(negedge clk);
    end

    repeat (10) @(negedge clk);
    check(exp_q.size() == 0, "frames_outstanding", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
